// File: rtl/prio_encoder_stream.sv
// Streaming priority encoder: captures an N-bit request vector and emits each set index, one per beat.
// Define PRIO_LSB_FIRST_EN for lowest-bit-first order; the default is highest-bit-first.
module prio_encoder_stream #(
   parameter int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_vec,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         out_last,
   output logic [W-1:0] out_seq,
   output logic         busy
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t         state;
   logic [N-1:0]   pend;
   logic [W-1:0]   seq;
   logic [W-1:0]   pidx;
   logic           one_hot;

   // In IDLE pend is always zero, so the encoder naturally yields 0 there.
   always_comb begin
      pidx = '0;
`ifdef PRIO_LSB_FIRST_EN
      for (int i = N - 1; i >= 0; i--)
         if (pend[i]) pidx = W'(i);
`else
      for (int i = 0; i < N; i++)
         if (pend[i]) pidx = W'(i);
`endif
   end

   assign one_hot   = (pend != '0) && ((pend & (pend - N'(1))) == '0);

   assign in_ready  = (state == IDLE);
   assign busy      = (state == EMIT);
   assign out_valid = (state == EMIT);
   assign out_idx   = pidx;
   assign out_last  = (state == EMIT) && one_hot;
   assign out_seq   = seq;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pend  <= '0;
         seq   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_vec != '0) begin
                  pend  <= in_vec;
                  seq   <= '0;
                  state <= EMIT;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  pend[pidx] <= 1'b0;
                  if (one_hot) begin
                     seq   <= '0;
                     state <= IDLE;
                  end else begin
                     seq <= seq + W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prio_encoder_stream.sv
// Directed self-checking bench for prio_encoder_stream (N=8); expectations follow PRIO_LSB_FIRST_EN.
module tb_prio_encoder_stream;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_vec = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [2:0] out_idx;
   logic       out_last;
   logic [2:0] out_seq;
   logic       busy;

   int checks = 0;
   int errors = 0;

   prio_encoder_stream #(.N(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_idx(out_idx), .out_last(out_last), .out_seq(out_seq), .busy(busy)
   );

   always #5 clk = ~clk;

   // Present one vector for exactly one rising edge (DUT is idle when called).
   task automatic capture(input logic [7:0] v);
      @(negedge clk);
      in_vec = v;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #2;
      checks++;
      if ({in_ready, out_valid, out_idx, out_last, out_seq, busy} !== {1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset: rdy=%b vld=%b idx=%0d last=%b seq=%0d busy=%b, required 1 0 0 0 0 0",
                  in_ready, out_valid, out_idx, out_last, out_seq, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_two_beats;
      logic [2:0] e0, e1;
`ifdef PRIO_LSB_FIRST_EN
      e0 = 3'd1; e1 = 3'd7;
`else
      e0 = 3'd7; e1 = 3'd1;
`endif
      out_ready = 1'b1;
      capture(8'b1000_0010);
      @(negedge clk);
      checks++;
      if ({out_valid, out_idx, out_seq, out_last, busy, in_ready} !== {1'b1, e0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL two_beats_b0: vld=%b idx=%0d seq=%0d last=%b busy=%b rdy=%b, required 1 %0d 0 0 1 0",
                  out_valid, out_idx, out_seq, out_last, busy, in_ready, e0);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, out_idx, out_seq, out_last} !== {1'b1, e1, 3'd1, 1'b1}) begin
         errors++;
         $display("FAIL two_beats_b1: vld=%b idx=%0d seq=%0d last=%b, required 1 %0d 1 1",
                  out_valid, out_idx, out_seq, out_last, e1);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
         errors++;
         $display("FAIL two_beats_idle: vld=%b rdy=%b busy=%b, required 0 1 0", out_valid, in_ready, busy);
      end
   endtask

   task automatic test_all_ones;
      int busy_cnt;
      logic [2:0] e;
      busy_cnt = 0;
      out_ready = 1'b1;
      capture(8'hFF);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (i < 8) begin
`ifdef PRIO_LSB_FIRST_EN
            e = 3'(i);
`else
            e = 3'(7 - i);
`endif
            checks++;
            if ({out_valid, out_idx, out_seq, out_last} !== {1'b1, e, 3'(i), (i == 7)}) begin
               errors++;
               $display("FAIL all_ones_beat%0d: vld=%b idx=%0d seq=%0d last=%b, required 1 %0d %0d %b",
                        i, out_valid, out_idx, out_seq, out_last, e, i, (i == 7));
            end
         end
      end
      checks++;
      if (busy_cnt != 8) begin
         errors++;
         $display("FAIL all_ones_busy: busy cycles %0d, required 8", busy_cnt);
      end
   endtask

   task automatic test_stall;
      logic [2:0] e0, e1;
`ifdef PRIO_LSB_FIRST_EN
      e0 = 3'd2; e1 = 3'd5;
`else
      e0 = 3'd5; e1 = 3'd2;
`endif
      out_ready = 1'b0;
      capture(8'h24);
      // A new vector offered mid-stream must not be taken.
      in_valid = 1'b1;
      in_vec = 8'h01;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({out_valid, out_idx, out_seq, out_last, in_ready} !== {1'b1, e0, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stall_hold%0d: vld=%b idx=%0d seq=%0d last=%b rdy=%b, required 1 %0d 0 0 0",
                     i, out_valid, out_idx, out_seq, out_last, in_ready, e0);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_idx, out_seq, out_last} !== {1'b1, e1, 3'd1, 1'b1}) begin
         errors++;
         $display("FAIL stall_b1: vld=%b idx=%0d seq=%0d last=%b, required 1 %0d 1 1",
                  out_valid, out_idx, out_seq, out_last, e1);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL stall_idle: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_zero;
      out_ready = 1'b1;
      capture(8'h00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({out_valid, in_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL zero_vec%0d: vld=%b rdy=%b busy=%b, required 0 1 0", i, out_valid, in_ready, busy);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [2:0] e0;
`ifdef PRIO_LSB_FIRST_EN
      e0 = 3'd4;
`else
      e0 = 3'd7;
`endif
      out_ready = 1'b1;
      capture(8'hF0);
      @(negedge clk);
      checks++;
      if ({out_valid, out_idx} !== {1'b1, e0}) begin
         errors++;
         $display("FAIL rstmid_b0: vld=%b idx=%0d, required 1 %0d", out_valid, out_idx, e0);
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, busy, in_ready} !== 3'b001) begin
         errors++;
         $display("FAIL rstmid_async: vld=%b busy=%b rdy=%b, required 0 0 1", out_valid, busy, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_after%0d: vld=%b rdy=%b, required 0 1", i, out_valid, in_ready);
         end
      end
   endtask

   initial begin
      test_reset;
      test_two_beats;
      test_all_ones;
      test_stall;
      test_zero;
      test_reset_mid;
      test_two_beats;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
